// File: rtl/param_cache_ctrl_if.sv
// ----------------------------------------------------------------------------
// param_cache_ctrl_if
// Bus bundle for the direct-mapped cache controller: the CPU data port and
// the backing-RAM port.
//   slave  : controller view (takes CPU requests and memory beats, drives
//            CPU responses and memory requests)
//   master : environment view (CPU + memory side)
// CPU port : CPU_REQ/CPU_WR/CPU_ADDR/CPU_WDATA in, CPU_RDATA/CPU_READY out
// MEM port : MEM_REQ/MEM_WR/MEM_ADDR/MEM_WDATA out, MEM_RDATA/MEM_ACK in
// ----------------------------------------------------------------------------
interface param_cache_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          CPU_REQ;
   logic          CPU_WR;
   logic [AW-1:0] CPU_ADDR;
   logic [DW-1:0] CPU_WDATA;
   logic [DW-1:0] CPU_RDATA;
   logic          CPU_READY;
   logic          MEM_REQ;
   logic          MEM_WR;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_WDATA;
   logic [DW-1:0] MEM_RDATA;
   logic          MEM_ACK;

   modport slave (
      input  CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
      output CPU_RDATA, CPU_READY, MEM_REQ, MEM_WR, MEM_ADDR, MEM_WDATA
   );

   modport master (
      output CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
      input  CPU_RDATA, CPU_READY, MEM_REQ, MEM_WR, MEM_ADDR, MEM_WDATA
   );
endinterface

// File: rtl/param_cache_ctrl.sv
// ----------------------------------------------------------------------------
// param_cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache controller between a
// CPU data port and a backing RAM with variable-latency valid/ack beats.
// Read misses refill the whole line (WORDS beats); writes always go to memory
// and update the cached copy only on a hit.
//
// Ports:
//   CLK      clock, rising edge
//   RST      synchronous active-high reset
//   bus      param_cache_ctrl_if.slave (CPU port + memory port)
//   HIT_CNT  lookup hit counter   (only with CACHE_STATS_EN)
//   MISS_CNT lookup miss counter  (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN
// ----------------------------------------------------------------------------
module param_cache_ctrl #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   param_cache_ctrl_if.slave    bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]          HIT_CNT,
   output logic [31:0]          MISS_CNT
`endif
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TB = AW - OB - IB;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_REFILL, S_RESPOND, S_WRITE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          wr_q, wr_d;
   logic [OB-1:0] beat_q, beat_d;

   logic [DW-1:0] rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          mreq_q, mreq_d;
   logic          mwr_q, mwr_d;
   logic [AW-1:0] maddr_q, maddr_d;
   logic [DW-1:0] mwdata_q, mwdata_d;

   logic [LINES-1:0] valid_q;
   logic [TB-1:0]    tag_q  [LINES];
   logic [DW-1:0]    data_q [LINES*WORDS];

   // Fields of the latched request
   logic [OB-1:0]    off;
   logic [IB-1:0]    idx;
   logic [TB-1:0]    tag;
   logic [IB+OB-1:0] word_sel;
   logic             hit;
   logic             ack;
   logic [OB-1:0]    beat_nx;

   assign off      = addr_q[OB-1:0];
   assign idx      = addr_q[OB +: IB];
   assign tag      = addr_q[AW-1 : OB+IB];
   assign word_sel = addr_q[IB+OB-1:0];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   // Stray acks while no request is outstanding are dropped here
   assign ack      = bus.MEM_ACK && mreq_q;
   assign beat_nx  = beat_q + OB'(1);

   // Data-array write port and line-fill strobe
   logic             dw_en;
   logic [IB+OB-1:0] dw_sel;
   logic [DW-1:0]    dw_data;
   logic             line_fill;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      beat_d    = beat_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      mreq_d    = mreq_q;
      mwr_d     = mwr_q;
      maddr_d   = maddr_q;
      mwdata_d  = mwdata_q;
      dw_en     = 1'b0;
      dw_sel    = {idx, beat_q};
      dw_data   = bus.MEM_RDATA;
      line_fill = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.CPU_REQ) begin
               addr_d  = bus.CPU_ADDR;
               wdata_d = bus.CPU_WDATA;
               wr_d    = bus.CPU_WR;
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (wr_q) begin
               mreq_d   = 1'b1;
               mwr_d    = 1'b1;
               maddr_d  = addr_q;
               mwdata_d = wdata_q;
               state_d  = S_WRITE;
            end else if (hit) begin
               rdata_d = data_q[word_sel];
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               beat_d  = '0;
               mreq_d  = 1'b1;
               mwr_d   = 1'b0;
               maddr_d = {tag, idx, {OB{1'b0}}};
               state_d = S_REFILL;
            end
         end

         S_REFILL: begin
            if (ack) begin
               dw_en  = 1'b1;
               beat_d = beat_nx;
               if (beat_q == OB'(WORDS-1)) begin
                  line_fill = 1'b1;
                  mreq_d    = 1'b0;
                  state_d   = S_RESPOND;
               end else begin
                  maddr_d = {tag, idx, beat_nx};
               end
            end
         end

         S_RESPOND: begin
            // Line was written at the last-beat edge, so it is readable now
            rdata_d = data_q[word_sel];
            ready_d = 1'b1;
            state_d = S_IDLE;
         end

         S_WRITE: begin
            if (ack) begin
               mreq_d  = 1'b0;
               mwr_d   = 1'b0;
               ready_d = 1'b1;
               state_d = S_IDLE;
               // Tags cannot change while the write is pending, so the
               // hit computed here equals the one seen in LOOKUP
               if (hit) begin
                  dw_en   = 1'b1;
                  dw_sel  = word_sel;
                  dw_data = wdata_q;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         beat_q   <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         mreq_q   <= 1'b0;
         mwr_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         beat_q   <= beat_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         mreq_q   <= mreq_d;
         mwr_q    <= mwr_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         if (line_fill) valid_q[idx] <= 1'b1;
      end
   end

   // Tags and data are not reset; the valid bits alone qualify them
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (line_fill) tag_q[idx] <= tag;
         if (dw_en) data_q[dw_sel] <= dw_data;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // One of the two counters steps on every lookup, reads and writes alike
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
         else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign HIT_CNT  = hit_cnt_q;
   assign MISS_CNT = miss_cnt_q;
`endif

   assign bus.CPU_RDATA = rdata_q;
   assign bus.CPU_READY = ready_q;
   assign bus.MEM_REQ   = mreq_q;
   assign bus.MEM_WR    = mwr_q;
   assign bus.MEM_ADDR  = maddr_q;
   assign bus.MEM_WDATA = mwdata_q;

endmodule

// File: tb/tb_param_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_param_cache_ctrl
// Directed scenarios followed by random traffic against a reference model:
// the model tracks which line tags are resident and what memory holds, and
// predicts hit/miss, the memory beat sequence and the returned data.
// ----------------------------------------------------------------------------
module tb_param_cache_ctrl;
   localparam int LINES = 16;
   localparam int WORDS = 4;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   param_cache_ctrl_if #(.DW(32), .AW(32)) bus();

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   param_cache_ctrl #(.DW(32), .AW(32), .LINES(LINES), .WORDS(WORDS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
`ifdef CACHE_STATS_EN
      ,
      .HIT_CNT  (hit_cnt),
      .MISS_CNT (miss_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- memory model + responder ----------------
   typedef struct {
      bit        wr;
      bit [31:0] addr;
      bit [31:0] data;
   } beat_t;

   bit [31:0] mem_w [bit [31:0]];
   beat_t     mlog [$];
   int        lat = 0;

   function automatic bit [31:0] memval(input bit [31:0] a);
      return mem_w.exists(a) ? mem_w[a] : a + 32'h100;
   endfunction

   initial begin
      int        wcnt;
      bit [31:0] hold_addr;
      beat_t     b;
      wcnt = 0;
      hold_addr = '0;
      bus.MEM_ACK   = 1'b0;
      bus.MEM_RDATA = '0;
      forever begin
         @(posedge CLK); #1;
         bus.MEM_ACK = 1'b0;
         if (RST || !bus.MEM_REQ) begin
            wcnt = 0;
         end else begin
            if (wcnt == 0) hold_addr = bus.MEM_ADDR;
            else chk("mem_addr_hold", bus.MEM_ADDR, hold_addr);
            if (wcnt >= lat) begin
               b.wr   = bus.MEM_WR;
               b.addr = bus.MEM_ADDR;
               b.data = bus.MEM_WDATA;
               mlog.push_back(b);
               if (b.wr) mem_w[b.addr] = b.data;
               else      bus.MEM_RDATA = memval(b.addr);
               bus.MEM_ACK = 1'b1;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // ---------------- cache reference model ----------------
   bit        mv   [LINES];
   bit [31:0] mtag [LINES];
   int        exp_hit = 0;
   int        exp_miss = 0;

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
      exp_hit  = 0;
      exp_miss = 0;
   endtask

   task automatic stats_chk(input string tag);
`ifdef CACHE_STATS_EN
      chk({tag, "_hits"},   hit_cnt,  exp_hit);
      chk({tag, "_misses"}, miss_cnt, exp_miss);
`else
      if (tag.len() == 0) $display("stats off");
`endif
   endtask

   task automatic cpu_txn(input bit wr, input bit [31:0] a, input bit [31:0] d);
      int        idx;
      bit [31:0] tg;
      bit        hit;
      bit [31:0] expd;
      bit [31:0] base;
      int        edges;
      bit        seen;
      idx   = int'((a / WORDS) % LINES);
      tg    = a / (WORDS * LINES);
      hit   = mv[idx] && (mtag[idx] == tg);
      expd  = memval(a);
      base  = a - (a % WORDS);
      edges = 0;
      seen  = 1'b0;
      mlog.delete();
      bus.CPU_REQ   = 1'b1;
      bus.CPU_WR    = wr;
      bus.CPU_ADDR  = a;
      bus.CPU_WDATA = d;
      while (edges < 400 && !seen) begin
         @(posedge CLK); #2;
         edges++;
         seen = bus.CPU_READY;
      end
      bus.CPU_REQ = 1'b0;
      chk("cpu_ready", seen, 1'b1);
      if (hit) exp_hit++;
      else     exp_miss++;
      if (wr) begin
         chk("wr_beats", mlog.size(), 1);
         if (mlog.size() == 1) begin
            chk("wr_flag", mlog[0].wr, 1'b1);
            chk("wr_addr", mlog[0].addr, a);
            chk("wr_data", mlog[0].data, d);
         end
      end else begin
         chk("rdata", bus.CPU_RDATA, expd);
         if (hit) begin
            chk("hit_latency", edges, 2);
            chk("hit_no_mem", mlog.size(), 0);
         end else begin
            chk("refill_beats", mlog.size(), WORDS);
            for (int i = 0; i < mlog.size() && i < WORDS; i++) begin
               chk("refill_wr", mlog[i].wr, 1'b0);
               chk("refill_addr", mlog[i].addr, base + i);
            end
            mv[idx]   = 1'b1;
            mtag[idx] = tg;
         end
      end
      @(posedge CLK); #2;
      chk("ready_pulse", bus.CPU_READY, 1'b0);
      if (!wr) chk("rdata_hold", bus.CPU_RDATA, expd);
   endtask

   initial begin
      int n;
      bus.CPU_REQ   = 1'b0;
      bus.CPU_WR    = 1'b0;
      bus.CPU_ADDR  = '0;
      bus.CPU_WDATA = '0;
      RST = 1'b1;
      model_reset();
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b0;
      chk("rst_ready", bus.CPU_READY, 1'b0);
      chk("rst_mem_req", bus.MEM_REQ, 1'b0);
      chk("rst_mem_wr", bus.MEM_WR, 1'b0);
      chk("rst_rdata", bus.CPU_RDATA, 32'h0);
      chk("rst_mem_addr", bus.MEM_ADDR, 32'h0);
      chk("rst_mem_wdata", bus.MEM_WDATA, 32'h0);
      stats_chk("rst");

      // Directed: cold miss, hit, conflict eviction, write hit / miss
      lat = 0;
      cpu_txn(1'b0, 32'h5,   32'h0);
      cpu_txn(1'b0, 32'h6,   32'h0);
      cpu_txn(1'b0, 32'h45,  32'h0);
      cpu_txn(1'b0, 32'h5,   32'h0);
      cpu_txn(1'b1, 32'h6,   32'hDEADBEEF);
      cpu_txn(1'b0, 32'h6,   32'h0);
      cpu_txn(1'b1, 32'h100, 32'h12345678);
      cpu_txn(1'b0, 32'h100, 32'h0);
      stats_chk("directed");

      // Slow memory: address held stable during every wait
      lat = 3;
      cpu_txn(1'b0, 32'h84, 32'h0);
      cpu_txn(1'b1, 32'h85, 32'hA5A5_0001);

      // Reset in the middle of a refill of 0x20
      mlog.delete();
      bus.CPU_REQ  = 1'b1;
      bus.CPU_WR   = 1'b0;
      bus.CPU_ADDR = 32'h20;
      n = 0;
      while (mlog.size() < 2 && n < 200) begin
         @(posedge CLK); #2;
         n++;
      end
      chk("rst_mid_reached", mlog.size() >= 2, 1'b1);
      RST = 1'b1;
      bus.CPU_REQ = 1'b0;
      @(posedge CLK); #2;
      chk("rst_mid_mem_req", bus.MEM_REQ, 1'b0);
      chk("rst_mid_ready", bus.CPU_READY, 1'b0);
      RST = 1'b0;
      model_reset();
      stats_chk("rst_mid");
      cpu_txn(1'b0, 32'h20, 32'h0);
      cpu_txn(1'b0, 32'h84, 32'h0);

      // Random traffic over a small address window to force hits/conflicts
      for (int k = 0; k < 80; k++) begin
         lat = $urandom_range(0, 3);
         cpu_txn(($urandom_range(0, 3) == 0), 32'($urandom_range(0, 511)), $urandom);
      end
      stats_chk("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
